// File: rtl/mips_opcode_decoder_if.sv
// mips_opcode_decoder_if: bundles the opcode input, its qualifier and every
// decoder result into one interface.
// The slave side is the decoder.
// The master side is the decode-stage producer or consumer.
interface mips_opcode_decoder_if #(
  parameter int CNT_W = 32
);

  logic [5:0]       opcode;
  logic             op_valid;
  logic             rtype;
  logic             itype;
  logic             jtype;
  logic             is_link;
  logic             is_branch;
  logic             is_imm_alu;
  logic             is_load;
  logic             is_store;
  logic             illegal;
  logic             illegal_seen;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] i_count;
  logic [CNT_W-1:0] j_count;

  modport master (
    output opcode, op_valid,
    input  rtype, itype, jtype, is_link, is_branch, is_imm_alu,
           is_load, is_store, illegal, illegal_seen,
           r_count, i_count, j_count
  );

  modport slave (
    input  opcode, op_valid,
    output rtype, itype, jtype, is_link, is_branch, is_imm_alu,
           is_load, is_store, illegal, illegal_seen,
           r_count, i_count, j_count
  );

endinterface

// File: rtl/mips_opcode_decoder.sv
// mips_opcode_decoder: classifies the 6-bit primary opcode.
// Each opcode maps to exactly one of R-, I- or J-type.
// It also produces the coarse sub-class flags used by the main control decoder.
//
// Optional statistics are compiled in with the macro OPCODE_DECODER_STATS_EN.
// - The statistics are per-class counters plus a sticky illegal flag.
// - Without the macro the block is purely combinational.
// - In that case the count and sticky outputs read as zero.
module mips_opcode_decoder #(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  mips_opcode_decoder_if.slave bus
);

  logic rtype_c;
  logic jtype_c;
  logic itype_c;
  logic illegal_c;

  // Decode classes and sub-classes from the opcode alone.
  // REGIMM (000001) and the reserved 011xxx space still fall into I-type.
  always_comb begin
    rtype_c        = 1'b0;
    jtype_c        = 1'b0;
    itype_c        = 1'b0;
    illegal_c      = 1'b0;
    bus.is_link    = 1'b0;
    bus.is_branch  = 1'b0;
    bus.is_imm_alu = 1'b0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;

    rtype_c        = (bus.opcode == 6'b000000);
    jtype_c        = (bus.opcode[5:1] == 5'b00001);
    itype_c        = ~(rtype_c | jtype_c);
    illegal_c      = (bus.opcode[5:3] == 3'b011);
    bus.is_link    = (bus.opcode == 6'b000011);
    bus.is_branch  = (bus.opcode[5:2] == 4'b0001) || (bus.opcode == 6'b000001);
    bus.is_imm_alu = (bus.opcode[5:3] == 3'b001);
    bus.is_load    = (bus.opcode[5:3] == 3'b100);
    bus.is_store   = (bus.opcode[5:3] == 3'b101);
  end

  assign bus.rtype   = rtype_c;
  assign bus.jtype   = jtype_c;
  assign bus.itype   = itype_c;
  assign bus.illegal = illegal_c;

`ifdef OPCODE_DECODER_STATS_EN

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] i_cnt;
  logic [CNT_W-1:0] j_cnt;
  logic             illegal_sticky;

  // Count valid opcodes per class and remember any valid illegal opcode.
  // Reset takes priority over a simultaneous op_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      i_cnt          <= '0;
      j_cnt          <= '0;
      illegal_sticky <= 1'b0;
    end else if (bus.op_valid) begin
      if (rtype_c) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (jtype_c) begin
        j_cnt <= j_cnt + 1'b1;
      end else begin
        i_cnt <= i_cnt + 1'b1;
      end
      if (illegal_c) begin
        illegal_sticky <= 1'b1;
      end
    end
  end

  assign bus.r_count      = r_cnt;
  assign bus.i_count      = i_cnt;
  assign bus.j_count      = j_cnt;
  assign bus.illegal_seen = illegal_sticky;

`else

  // Without statistics the clock, reset and qualifier have no consumer.
  logic unused_stats_inputs;
  assign unused_stats_inputs = ^{clk, rst, bus.op_valid};

  assign bus.r_count      = '0;
  assign bus.i_count      = '0;
  assign bus.j_count      = '0;
  assign bus.illegal_seen = 1'b0;

`endif

endmodule

// File: tb/tb_mips_opcode_decoder.sv
// tb_mips_opcode_decoder: directed checks of the opcode classifier.
// Covers a directed flag table and a one-hot sweep over all 64 opcodes.
// Also covers the statistics counters and sticky flag.
// When OPCODE_DECODER_STATS_EN is not defined, those read as zero.
module tb_mips_opcode_decoder;

`ifdef OPCODE_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_opcode_decoder_if #(.CNT_W(32)) bus ();

  mips_opcode_decoder #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Directed table: opcode and flags.
  // Flag order is {rtype,itype,jtype,is_link,is_branch,is_imm_alu,is_load,is_store,illegal}.
  typedef struct {
    logic [5:0] op;
    logic [8:0] flags;
  } vec_t;

  vec_t vecs[16] = '{
    '{6'b000000, 9'b100000000},
    '{6'b000010, 9'b001000000},
    '{6'b000011, 9'b001100000},
    '{6'b100010, 9'b010000100},
    '{6'b010011, 9'b010000000},
    '{6'b011000, 9'b010000001},
    '{6'b000001, 9'b010010000},
    '{6'b000100, 9'b010010000},
    '{6'b000111, 9'b010010000},
    '{6'b001000, 9'b010001000},
    '{6'b001111, 9'b010001000},
    '{6'b101011, 9'b010000010},
    '{6'b100011, 9'b010000100},
    '{6'b111111, 9'b010000000},
    '{6'b011111, 9'b010000001},
    '{6'b110000, 9'b010000000}
  };

  function automatic logic [31:0] stat_exp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic valid);
    bus.opcode   = op;
    bus.op_valid = valid;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] flags_now();
    return {bus.rtype, bus.itype, bus.jtype, bus.is_link, bus.is_branch,
            bus.is_imm_alu, bus.is_load, bus.is_store, bus.illegal};
  endfunction

  task automatic checkStats(input string tag, input int r, input int i,
                            input int j, input bit seen);
    checkOutput({tag, "_r"}, bus.r_count, stat_exp(r));
    checkOutput({tag, "_i"}, bus.i_count, stat_exp(i));
    checkOutput({tag, "_j"}, bus.j_count, stat_exp(j));
    checkOutput({tag, "_seen"}, 32'(bus.illegal_seen), stat_exp(int'(seen)));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.opcode   = 6'b000000;
    bus.op_valid = 1'b0;

    // Reset state.
    tick();
    rst = 1'b0;
    checkStats("reset", 0, 0, 0, 1'b0);

    // Directed flag table, with op_valid off so nothing is counted.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].op, 1'b0);
      checkOutput($sformatf("flags_%b", vecs[k].op), 32'(flags_now()),
                  32'(vecs[k].flags));
    end

    // The combinational result must not depend on op_valid.
    applyStimulus(6'b000011, 1'b1);
    checkOutput("flags_valid_ignored", 32'(flags_now()), 32'(9'b001100000));
    applyStimulus(6'b000011, 1'b0);

    // Sweep all 64 opcodes for one-hot classification.
    for (int op = 0; op < 64; op++) begin
      applyStimulus(6'(op), 1'b0);
      checkOutput($sformatf("onehot_%0d", op),
                  32'(bus.rtype) + 32'(bus.itype) + 32'(bus.jtype), 32'd1);
    end
    tick();
    checkStats("sweep_nocount", 0, 0, 0, 1'b0);

    // Counting sequence: R, J, I (load), J (JAL).
    applyStimulus(6'b000000, 1'b1); tick();
    applyStimulus(6'b000010, 1'b1); tick();
    applyStimulus(6'b100011, 1'b1); tick();
    applyStimulus(6'b000011, 1'b1); tick();
    checkStats("count4", 1, 1, 2, 1'b0);

    // A deasserted op_valid leaves the counts alone, even for an illegal opcode.
    applyStimulus(6'b011000, 1'b0); tick(); tick();
    checkStats("hold", 1, 1, 2, 1'b0);

    // A valid illegal opcode sets the sticky flag and counts as I-type.
    applyStimulus(6'b011000, 1'b1); tick();
    checkStats("illegal", 1, 2, 2, 1'b1);
    applyStimulus(6'b000000, 1'b1); tick();
    checkStats("sticky", 2, 2, 2, 1'b1);

    // Reset wins over a simultaneous op_valid.
    rst = 1'b1;
    applyStimulus(6'b000000, 1'b1); tick();
    checkStats("rst_wins", 0, 0, 0, 1'b0);

    // Counting resumes once reset drops.
    rst = 1'b0;
    applyStimulus(6'b000010, 1'b1); tick();
    checkStats("resume", 0, 0, 1, 1'b0);
    applyStimulus(6'b000010, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
